// File: rtl/packer_pkg.sv
// Shared constants and helpers for the pipeline result packer.
//   DEF_DATA_WIDTH / DEF_BEATS / DEF_FIFO_DEPTH : default parameter values
//   asm_state_t                                 : assembler state encoding
//   level_width()                               : width of a 0..depth occupancy count
package packer_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_BEATS      = 4;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic {
      ST_EMPTY   = 1'b0,
      ST_FILLING = 1'b1
   } asm_state_t;

   // The count has to reach depth itself, so it needs room for depth+1 values.
   function automatic int level_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/packer_fifo.sv
// First-word-fall-through word buffer for the result packer.
//   clk, rst     : clock, asynchronous active-low reset
//   i_push       : write request for i_push_data
//   i_push_data  : entry to store ({partial, word} in the packer)
//   i_pop        : remove the head entry (ignored when empty)
//   o_head       : head entry, straight from storage
//   o_level      : number of entries held
//   o_push_ok    : this cycle's push is accepted (room, or a pop frees a slot)
module packer_fifo
   import packer_pkg::*;
#(
   parameter int WIDTH   = 33,
   parameter int DEPTH   = DEF_FIFO_DEPTH,
   parameter int LEVEL_W = level_width(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_push,
   input  logic [WIDTH-1:0]   i_push_data,
   input  logic               i_pop,
   output logic [WIDTH-1:0]   o_head,
   output logic [LEVEL_W-1:0] o_level,
   output logic               o_push_ok
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [LEVEL_W-1:0] r_level;

   logic w_full;
   logic w_pop;

   assign w_full    = (r_level == LEVEL_W'(DEPTH));
   assign w_pop     = i_pop && (r_level != '0);
   // When full, a same-cycle pop frees the slot the write pointer is aiming at.
   assign o_push_ok = i_push && (!w_full || w_pop);

   assign o_head  = r_mem[r_rd_ptr];
   assign o_level = r_level;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (o_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({o_push_ok, w_pop})
            2'b10:   r_level <= r_level + LEVEL_W'(1);
            2'b01:   r_level <= r_level - LEVEL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/pipeline_result_packer.sv
// Packs BEATS result beats from the upstream pipeline into one output word and
// buffers finished words in a small FWFT FIFO. A partially filled word is
// flushed (unfilled lanes zero, out_partial=1) once the upstream goes idle.
//   clk, rst     : clock, asynchronous active-low reset
//   data_in      : result beat;  valid_in : beat qualifier
//   busy_in      : upstream still has work in flight (holds off a flush)
//   out_ready    : downstream takes the head word
//   clear_ovf    : clears the sticky overflow flag
//   out_data     : head word;  out_valid : head present
//   out_partial  : head word came from a flush
//   fifo_level   : words buffered;  overflow : a word was dropped
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_EMPTY   | no beats held, next beat goes to lane 0
// ST_FILLING | 1..BEATS-1 beats held, r_idx is the next lane
module pipeline_result_packer
   import packer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BEATS      = DEF_BEATS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [DATA_WIDTH-1:0]                 data_in,
   input  logic                                  valid_in,
   input  logic                                  busy_in,
   input  logic                                  out_ready,
   input  logic                                  clear_ovf,
   output logic [DATA_WIDTH*BEATS-1:0]           out_data,
   output logic                                  out_valid,
   output logic                                  out_partial,
   output logic [level_width(FIFO_DEPTH)-1:0]    fifo_level,
   output logic                                  overflow
);

   localparam int WORD_W  = DATA_WIDTH * BEATS;
   localparam int IDX_W   = $clog2(BEATS);
   localparam int LEVEL_W = level_width(FIFO_DEPTH);

   asm_state_t          r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [WORD_W-1:0]   r_lanes;
   logic                r_overflow;

   logic [WORD_W-1:0]   w_lanes_next;
   logic                w_last;
   logic                w_complete;
   logic                w_flush;
   logic                w_push;
   logic [WORD_W:0]     w_push_entry;
   logic                w_push_ok;
   logic                w_pop;
   logic [WORD_W:0]     w_head;
   logic [LEVEL_W-1:0]  w_level;

   always_comb begin
      w_lanes_next = r_lanes;
      w_lanes_next[r_idx*DATA_WIDTH +: DATA_WIDTH] = data_in;
   end

   assign w_last     = (r_idx == IDX_W'(BEATS - 1));
   assign w_complete = valid_in && w_last;
   // A new beat always wins over a flush; busy_in only matters while filling.
   assign w_flush    = (r_state == ST_FILLING) && !valid_in && !busy_in;
   assign w_push     = w_complete || w_flush;
   // Lanes are cleared after every push, so a flushed word has zeroed upper lanes.
   assign w_push_entry = w_complete ? {1'b0, w_lanes_next} : {1'b1, r_lanes};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_EMPTY;
         r_idx   <= '0;
         r_lanes <= '0;
      end else begin
         if (valid_in) begin
            if (w_last) begin
               r_state <= ST_EMPTY;
               r_idx   <= '0;
               r_lanes <= '0;
            end else begin
               r_state <= ST_FILLING;
               r_idx   <= r_idx + IDX_W'(1);
               r_lanes <= w_lanes_next;
            end
         end else if (w_flush) begin
            r_state <= ST_EMPTY;
            r_idx   <= '0;
            r_lanes <= '0;
         end
      end
   end

   // Setting wins over clearing so a drop in the clear cycle is not lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow <= 1'b0;
      end else if (w_push && !w_push_ok) begin
         r_overflow <= 1'b1;
      end else if (clear_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   assign w_pop = out_valid && out_ready;

   packer_fifo #(
      .WIDTH   (WORD_W + 1),
      .DEPTH   (FIFO_DEPTH),
      .LEVEL_W (LEVEL_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_level     (w_level),
      .o_push_ok   (w_push_ok)
   );

   assign fifo_level  = w_level;
   assign out_valid   = (w_level != '0);
   assign out_data    = w_head[WORD_W-1:0];
   assign out_partial = w_head[WORD_W];
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_pipeline_result_packer.sv
// Directed and randomized checks of pipeline_result_packer against a queue-based
// reference model (DATA_WIDTH=8, BEATS=4, FIFO_DEPTH=4).
module tb_pipeline_result_packer;

   localparam int DW    = 8;
   localparam int BEATS = 4;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          valid_in = 1'b0;
   logic          busy_in = 1'b0;
   logic          out_ready = 1'b0;
   logic          clear_ovf = 1'b0;
   logic [31:0]   out_data;
   logic          out_valid;
   logic          out_partial;
   logic [2:0]    fifo_level;
   logic          overflow;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: beats held so far, queued {partial, word}, sticky flag.
   logic [7:0]  m_beats [$];
   logic [32:0] m_fifo  [$];
   bit          m_ovf = 1'b0;

   always #5 clk = ~clk;

   pipeline_result_packer #(
      .DATA_WIDTH (DW),
      .BEATS      (BEATS),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .busy_in     (busy_in),
      .out_ready   (out_ready),
      .clear_ovf   (clear_ovf),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_partial (out_partial),
      .fifo_level  (fifo_level),
      .overflow    (overflow)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pack_beats();
      logic [31:0] w = '0;
      foreach (m_beats[i]) w = w | (32'(m_beats[i]) << (8 * i));
      return w;
   endfunction

   task automatic model_step(input bit v, input logic [7:0] d, input bit b,
                             input bit r, input bit c);
      bit          pop;
      bit          have_push = 1'b0;
      bit          accept;
      logic [32:0] entry = '0;
      pop = (m_fifo.size() != 0) && r;
      if (v) begin
         m_beats.push_back(d);
         if (m_beats.size() == BEATS) begin
            entry = {1'b0, pack_beats()};
            have_push = 1'b1;
            m_beats.delete();
         end
      end else if (m_beats.size() != 0 && !b) begin
         entry = {1'b1, pack_beats()};
         have_push = 1'b1;
         m_beats.delete();
      end
      accept = have_push && ((m_fifo.size() < DEPTH) || pop);
      if (pop) void'(m_fifo.pop_front());
      if (accept) m_fifo.push_back(entry);
      if (have_push && !accept) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
   endtask

   task automatic check_all();
      logic [32:0] head;
      chk("valid", 64'(out_valid), 64'(m_fifo.size() != 0));
      chk("level", 64'(fifo_level), 64'(m_fifo.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (m_fifo.size() != 0) begin
         head = m_fifo[0];
         chk("data", 64'(out_data), 64'(head[31:0]));
         chk("partial", 64'(out_partial), 64'(head[32]));
      end
   endtask

   // One clock: drive inputs, advance the model, then sample after the edge.
   task automatic step(input bit v, input logic [7:0] d, input bit b,
                       input bit r, input bit c);
      valid_in  = v;
      data_in   = d;
      busy_in   = b;
      out_ready = r;
      clear_ovf = c;
      model_step(v, d, b, r, c);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic send_word(input bit r_last, input bit c_last);
      for (int i = 0; i < BEATS; i++) begin
         step(1'b1, 8'($urandom_range(0, 255)), 1'b1,
              (i == BEATS - 1) ? r_last : 1'b0,
              (i == BEATS - 1) ? c_last : 1'b0);
      end
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Full word with downstream ready
      step(1'b1, 8'h11, 1'b1, 1'b1, 1'b0);
      step(1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
      step(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
      chk("w033_valid_pre", 64'(out_valid), 64'd0);
      step(1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
      chk("w033_valid", 64'(out_valid), 64'd1);
      chk("w033_data", 64'(out_data), 64'h44332211);
      chk("w033_partial", 64'(out_partial), 64'd0);
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("w033_valid_post", 64'(out_valid), 64'd0);

      // Flush of a partial word, then a full word lands in lane 0 again
      step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("flush_data", 64'(out_data), 64'h0000BBAA);
      chk("flush_partial", 64'(out_partial), 64'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
      chk("after_flush_data", 64'(out_data), 64'h04030201);
      chk("after_flush_partial", 64'(out_partial), 64'd0);
      drain(2);

      // Full FIFO with a pop on the completing cycle: no drop
      for (int w = 0; w < DEPTH; w++) send_word(1'b0, 1'b0);
      chk("full_level", 64'(fifo_level), 64'd4);
      send_word(1'b1, 1'b0);
      chk("pop_push_level", 64'(fifo_level), 64'd4);
      chk("pop_push_ovf", 64'(overflow), 64'd0);
      drain(5);
      chk("drained_level", 64'(fifo_level), 64'd0);

      // Five words with no downstream: fifth dropped
      for (int w = 0; w < 5; w++) send_word(1'b0, 1'b0);
      chk("ovf_level", 64'(fifo_level), 64'd4);
      chk("ovf_set", 64'(overflow), 64'd1);
      drain(5);

      // Clear on idle, then clear colliding with an overflowing push
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("ovf_cleared", 64'(overflow), 64'd0);
      for (int w = 0; w < DEPTH; w++) send_word(1'b0, 1'b0);
      send_word(1'b0, 1'b1);
      chk("ovf_set_wins", 64'(overflow), 64'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("ovf_clear_idle", 64'(overflow), 64'd0);
      drain(2);

      // Reset mid-word with words buffered
      step(1'b1, 8'hE1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'hE2, 1'b1, 1'b0, 1'b0);
      #3;
      rst = 1'b0;
      #1;
      chk("mid_rst_level", 64'(fifo_level), 64'd0);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_data", 64'(out_data), 64'd0);
      chk("mid_rst_partial", 64'(out_partial), 64'd0);
      m_beats.delete();
      m_fifo.delete();
      m_ovf = 1'b0;
      @(posedge clk);
      #1;
      chk("in_rst_level", 64'(fifo_level), 64'd0);
      rst = 1'b1;
      step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h04, 1'b1, 1'b0, 1'b0);
      chk("post_rst_data", 64'(out_data), 64'h04030201);
      drain(2);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 99) < 60, 8'($urandom_range(0, 255)),
              $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 55,
              $urandom_range(0, 99) < 5);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      drain(DEPTH + 1);
      chk("final_level", 64'(fifo_level), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
